// File: rtl/l1_cache_pkg.sv
// Shared types and geometry for the direct-mapped L1 cache.
// Address slicing: tag[29:5] index[4:2] offset[1:0] (word address).
package l1_cache_pkg;

  localparam int ADDR_W  = 30;
  localparam int DATA_W  = 32;
  localparam int INDEX_W = 3;
  localparam int OFFS_W  = 2;

  localparam int TAG_W   = ADDR_W - INDEX_W - OFFS_W;
  localparam int LINES   = 1 << INDEX_W;
  localparam int WORDS   = 1 << OFFS_W;
  localparam int LINE_W  = DATA_W * WORDS;
  localparam int BLK_W   = ADDR_W - OFFS_W;
  localparam int SEL_W   = $clog2(LINE_W);

  localparam int IDX_LSB = OFFS_W;
  localparam int TAG_LSB = OFFS_W + INDEX_W;

  typedef enum logic [1:0] {
    COMPARE,
    WRITEBACK,
    ALLOCATE
  } state_t;

endpackage

// File: rtl/l1_cache.sv
// Direct-mapped, write-back, write-allocate L1 cache.
// Ports: clk/proc_reset; proc_* CPU word side; mem_* 128-bit block side.
module l1_cache
  import l1_cache_pkg::*;
(
  input  logic              clk,
  input  logic              proc_reset,
  input  logic              proc_read,
  input  logic              proc_write,
  input  logic [ADDR_W-1:0] proc_addr,
  input  logic [DATA_W-1:0] proc_wdata,
  output logic              proc_stall,
  output logic [DATA_W-1:0] proc_rdata,
  output logic              mem_read,
  output logic              mem_write,
  output logic [BLK_W-1:0]  mem_addr,
  input  logic [LINE_W-1:0] mem_rdata,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic              mem_ready
);

  state_t state;
  state_t state_nx;

  logic [LINES-1:0]  valid;
  logic [LINES-1:0]  dirty;
  logic [TAG_W-1:0]  tags  [LINES];
  logic [LINE_W-1:0] lines [LINES];

  logic [TAG_W-1:0]   tag;
  logic [INDEX_W-1:0] idx;
  logic [OFFS_W-1:0]  off;
  logic [SEL_W-1:0]   wsel;

  logic req;
  logic hit;
  logic miss;

  // Block address of the miss being serviced; keeps the
  // memory side stable even if the CPU changes its request.
  logic [BLK_W-1:0]   miss_blk;
  logic [INDEX_W-1:0] m_idx;
  logic [TAG_W-1:0]   m_tag;

  assign tag  = proc_addr[ADDR_W-1:TAG_LSB];
  assign idx  = proc_addr[TAG_LSB-1:IDX_LSB];
  assign off  = proc_addr[OFFS_W-1:0];
  assign wsel = SEL_W'(off) << $clog2(DATA_W);

  assign req  = proc_read | proc_write;
  assign hit  = valid[idx] && (tags[idx] == tag);
  assign miss = req && !hit;

  assign m_idx = miss_blk[INDEX_W-1:0];
  assign m_tag = miss_blk[BLK_W-1:INDEX_W];

  assign proc_rdata = lines[idx][wsel +: DATA_W];

  always_ff @(posedge clk) begin
    if (proc_reset) begin
      state <= COMPARE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      COMPARE: begin
        if (miss) begin
          if (valid[idx] && dirty[idx]) begin
            state_nx = WRITEBACK;
          end else begin
            state_nx = ALLOCATE;
          end
        end
      end
      WRITEBACK: begin
        if (mem_ready) begin
          state_nx = req ? ALLOCATE : COMPARE;
        end
      end
      ALLOCATE: begin
        if (mem_ready) begin
          state_nx = COMPARE;
        end
      end
      default: state_nx = COMPARE;
    endcase
  end

  always_comb begin
    proc_stall = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    mem_addr   = miss_blk;
    mem_wdata  = lines[m_idx];
    unique case (state)
      COMPARE: begin
        proc_stall = miss;
      end
      WRITEBACK: begin
        proc_stall = 1'b1;
        mem_write  = 1'b1;
        mem_addr   = {tags[m_idx], m_idx};
      end
      ALLOCATE: begin
        proc_stall = 1'b1;
        mem_read   = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (proc_reset) begin
      miss_blk <= '0;
    end else if (state == COMPARE && miss) begin
      miss_blk <= proc_addr[ADDR_W-1:OFFS_W];
    end
  end

  always_ff @(posedge clk) begin
    if (proc_reset) begin
      valid <= '0;
      dirty <= '0;
    end else begin
      unique case (1'b1)
        (state == COMPARE) && proc_write && hit: begin
          lines[idx][wsel +: DATA_W] <= proc_wdata;
          dirty[idx] <= 1'b1;
        end
        (state == WRITEBACK) && mem_ready: begin
          dirty[m_idx] <= 1'b0;
        end
        (state == ALLOCATE) && mem_ready: begin
          lines[m_idx] <= mem_rdata;
          tags[m_idx]  <= m_tag;
          valid[m_idx] <= 1'b1;
          dirty[m_idx] <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_l1_cache.sv
// Directed bench for l1_cache with a latency-2 memory model
// and a read-data scoreboard backed by a flat shadow memory.
module tb_l1_cache;

  localparam int LAT = 2;

  logic         clk = 1'b0;
  logic         proc_reset = 1'b1;
  logic         proc_read = 1'b0;
  logic         proc_write = 1'b0;
  logic [29:0]  proc_addr = '0;
  logic [31:0]  proc_wdata = '0;
  logic         proc_stall;
  logic [31:0]  proc_rdata;
  logic         mem_read;
  logic         mem_write;
  logic [27:0]  mem_addr;
  logic [127:0] mem_rdata = '0;
  logic [127:0] mem_wdata;
  logic         mem_ready = 1'b0;

  int total = 0;
  int bad = 0;
  int rd_cnt = 0;
  int wr_cnt = 0;
  int cnt = 0;

  logic [127:0] mem [int];
  logic [31:0]  shadow [int];
  logic [31:0]  exp_q [$];

  l1_cache dut (
    .clk        (clk),
    .proc_reset (proc_reset),
    .proc_read  (proc_read),
    .proc_write (proc_write),
    .proc_addr  (proc_addr),
    .proc_wdata (proc_wdata),
    .proc_stall (proc_stall),
    .proc_rdata (proc_rdata),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .mem_addr   (mem_addr),
    .mem_rdata  (mem_rdata),
    .mem_wdata  (mem_wdata),
    .mem_ready  (mem_ready)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] pat_word(int b, int k);
    if (b == 4) return 32'hDDCCBBAA + k * 32'h01010101;
    return {8'(b), 8'(k), 16'h5A5A};
  endfunction

  function automatic logic [127:0] mem_block(int b);
    logic [127:0] v;
    if (mem.exists(b)) return mem[b];
    for (int k = 0; k < 4; k++) v[32*k +: 32] = pat_word(b, k);
    return v;
  endfunction

  function automatic logic [31:0] ref_word(int a);
    if (shadow.exists(a)) return shadow[a];
    return pat_word(a >> 2, a & 3);
  endfunction

  always @(posedge clk) begin
    #1;
    if (mem_ready) begin
      mem_ready = 1'b0;
      cnt = 0;
    end else if (mem_read || mem_write) begin
      if (cnt == LAT - 1) begin
        if (mem_write) begin
          mem[int'(mem_addr)] = mem_wdata;
          wr_cnt++;
        end else begin
          mem_rdata = mem_block(int'(mem_addr));
          rd_cnt++;
        end
        mem_ready = 1'b1;
      end else begin
        cnt++;
      end
    end else begin
      cnt = 0;
    end
  end

  always @(negedge clk) begin
    if (mem_read && mem_write) begin
      bad++;
      $error("FAIL rd_wr_excl observed=both expected=one");
    end
  end

  task automatic chk(string tag, logic [127:0] obs, logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic access(input bit rd, input bit wr,
                        input logic [29:0] a, input logic [31:0] d);
    @(negedge clk);
    proc_read = rd;
    proc_write = wr;
    proc_addr = a;
    proc_wdata = d;
    if (!wr) exp_q.push_back(ref_word(int'(a)));
    #1;
  endtask

  task automatic finish_req(string tag);
    int n = 0;
    logic [31:0] e;
    while (proc_stall && n < 60) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk({tag, "_done"}, 128'(proc_stall), 128'(0));
    if (!proc_write) begin
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hx;
      chk(tag, 128'(proc_rdata), 128'(e));
    end else begin
      shadow[int'(proc_addr)] = proc_wdata;
    end
  endtask

  task automatic wait_mem(bit want_rd, string tag);
    int n = 0;
    while (!(want_rd ? mem_read : mem_write) && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk({tag, "_seen"}, 128'(want_rd ? mem_read : mem_write), 128'(1));
  endtask

  task automatic idle();
    @(negedge clk);
    proc_read = 1'b0;
    proc_write = 1'b0;
    #1;
  endtask

  int r0;
  int w0;

  initial begin
    repeat (2) @(negedge clk);
    #1;
    chk("rst_stall", 128'(proc_stall), 128'(0));
    chk("rst_mrd", 128'(mem_read), 128'(0));
    chk("rst_mwr", 128'(mem_write), 128'(0));
    @(negedge clk);
    proc_reset = 1'b0;

    access(1, 0, 30'h10, 0);
    chk("miss_stall", 128'(proc_stall), 128'(1));
    @(negedge clk);
    #1;
    chk("miss_mrd", 128'(mem_read), 128'(1));
    chk("miss_maddr", 128'(mem_addr), 128'(28'h4));
    finish_req("rd_10");

    r0 = rd_cnt;
    access(1, 0, 30'h11, 0);
    chk("hit_stall", 128'(proc_stall), 128'(0));
    chk("hit_mrd", 128'(mem_read), 128'(0));
    finish_req("rd_11");

    access(0, 1, 30'h12, 32'h12345678);
    chk("wr_hit_stall", 128'(proc_stall), 128'(0));
    finish_req("wr_12");
    access(1, 0, 30'h12, 0);
    finish_req("rd_12");
    chk("no_mem_on_hits", 128'(rd_cnt - r0), 128'(0));

    access(1, 0, 30'h92, 0);
    chk("dirty_stall", 128'(proc_stall), 128'(1));
    wait_mem(0, "wb");
    chk("wb_addr", 128'(mem_addr), 128'(28'h4));
    chk("wb_word2", 128'(mem_wdata[95:64]), 128'(32'h12345678));
    wait_mem(1, "refill");
    chk("refill_addr", 128'(mem_addr), 128'(28'h24));
    finish_req("rd_92");

    access(1, 0, 30'h48, 0);
    void'(exp_q.pop_back());
    @(negedge clk);
    #1;
    chk("alloc_mrd", 128'(mem_read), 128'(1));
    proc_reset = 1'b1;
    proc_read = 1'b0;
    @(negedge clk);
    #1;
    chk("rst_abort_mrd", 128'(mem_read), 128'(0));
    proc_reset = 1'b0;
    access(1, 0, 30'h92, 0);
    chk("post_rst_miss", 128'(proc_stall), 128'(1));
    finish_req("rd_92_again");

    r0 = rd_cnt;
    w0 = wr_cnt;
    access(1, 1, 30'h64, 32'hCAFEF00D);
    finish_req("rw_64");
    chk("rw_one_refill", 128'(rd_cnt - r0), 128'(1));
    chk("rw_no_wb", 128'(wr_cnt - w0), 128'(0));
    access(1, 0, 30'h64, 0);
    finish_req("rd_64");
    access(1, 0, 30'h65, 0);
    finish_req("rd_65");
    access(1, 0, 30'h84, 0);
    wait_mem(0, "wb2");
    chk("wb2_addr", 128'(mem_addr), 128'(28'h19));
    chk("wb2_word0", 128'(mem_wdata[31:0]), 128'(32'hCAFEF00D));
    finish_req("rd_84");

    idle();
    chk("idle_stall", 128'(proc_stall), 128'(0));
    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
